// File: rtl/snake_text_pkg.sv
// rtl/snake_text_pkg.sv - shared constants and types for the text overlay
package snake_text_pkg;

  localparam int FONT_W      = 8;
  localparam int FONT_H      = 16;
  localparam int CHAR_ADDR_W = 8;
  localparam int CHAR_CODE_W = 7;
  localparam int FONT_ADDR_W = CHAR_CODE_W + 4;

  typedef logic [11:0] rgb12;

  // One pixel's worth of VGA timing plus colour, carried down the delay line
  typedef struct packed {
    logic [10:0] vcount;
    logic [10:0] hcount;
    logic        vsync;
    logic        vblnk;
    logic        hsync;
    logic        hblnk;
    rgb12        rgb;
  } vga_t;

endpackage

// File: rtl/font_rom.sv
// rtl/font_rom.sv - 8x16 ASCII glyph ROM with one-cycle registered read
//   clk  : clock
//   addr : {char_code[6:0], line[3:0]}
//   data : glyph row, MSB = leftmost pixel, valid one cycle after addr
module font_rom
  import snake_text_pkg::*;
(
  input  logic                   clk,
  input  logic [FONT_ADDR_W-1:0] addr,
  output logic [FONT_W-1:0]      data
);

  // Row 0 sits in the top byte; codes without a bitmap render blank
  function automatic logic [127:0] glyph(input logic [CHAR_CODE_W-1:0] code);
    case (code)
      7'h41:   glyph = 128'h1038_6cc6_c6fe_c6c6_c6c6_0000_0000_0000; // A
      7'h45:   glyph = 128'hfe66_6268_7868_6062_66fe_0000_0000_0000; // E
      7'h47:   glyph = 128'h3c66_c2c0_c0de_c6c6_663a_0000_0000_0000; // G
      7'h4d:   glyph = 128'hc6ee_fefe_d6c6_c6c6_c6c6_0000_0000_0000; // M
      7'h4f:   glyph = 128'h7cc6_c6c6_c6c6_c6c6_c67c_0000_0000_0000; // O
      7'h50:   glyph = 128'hfc66_6666_7c60_6060_60f0_0000_0000_0000; // P
      7'h52:   glyph = 128'hfc66_6666_7c6c_6666_66e6_0000_0000_0000; // R
      7'h56:   glyph = 128'hc6c6_c6c6_c6c6_c66c_3810_0000_0000_0000; // V
      default: glyph = '0;
    endcase
  endfunction

  logic [127:0] g;
  assign g = glyph(addr[FONT_ADDR_W-1:4]);

  always_ff @(posedge clk) begin
    data <= 8'(g >> {4'd15 - addr[3:0], 3'b000});
  end

endmodule

// File: rtl/draw_text.sv
// rtl/draw_text.sv - text box overlay on the VGA pixel stream
//   clk, rst_n            : pixel clock, synchronous active-low reset
//   enable                : overlay on; low passes the stream through
//   *count_in, *sync_in, *blnk_in, rgb_in : incoming stream
//   char_xy / char_code   : {row,col} to the text ROM / code back one cycle later
//   *_out                 : stream delayed by 4 cycles with glyphs overlaid
module draw_text
  import snake_text_pkg::*;
#(
  parameter int   XPOS         = 448,
  parameter int   YPOS         = 368,
  parameter int   COLS         = 16,
  parameter int   ROWS         = 1,
  parameter rgb12 FG_COLOR     = 12'hfff,
  parameter int   BLINK_FRAMES = 30
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic [10:0]            vcount_in,
  input  logic [10:0]            hcount_in,
  input  logic                   vsync_in,
  input  logic                   vblnk_in,
  input  logic                   hsync_in,
  input  logic                   hblnk_in,
  input  rgb12                   rgb_in,
  output logic [CHAR_ADDR_W-1:0] char_xy,
  input  logic [CHAR_CODE_W-1:0] char_code,
  output logic [10:0]            vcount_out,
  output logic [10:0]            hcount_out,
  output logic                   vsync_out,
  output logic                   vblnk_out,
  output logic                   hsync_out,
  output logic                   hblnk_out,
  output rgb12                   rgb_out
);

  // Box edges widened to 12 bits so XPOS + 8*COLS cannot wrap
  localparam logic [11:0] X0 = 12'(XPOS);
  localparam logic [11:0] X1 = 12'(XPOS + FONT_W * COLS);
  localparam logic [11:0] Y0 = 12'(YPOS);
  localparam logic [11:0] Y1 = 12'(YPOS + FONT_H * ROWS);

  logic       in_box;
  logic [6:0] dx;
  logic [7:0] dy;
  vga_t       tim_in;

  assign in_box = ({1'b0, hcount_in} >= X0) && ({1'b0, hcount_in} < X1) &&
                  ({1'b0, vcount_in} >= Y0) && ({1'b0, vcount_in} < Y1);
  assign dx     = 7'(hcount_in - 11'(XPOS));
  assign dy     = 8'(vcount_in - 11'(YPOS));
  assign tim_in = {vcount_in, hcount_in, vsync_in, vblnk_in, hsync_in, hblnk_in, rgb_in};

  logic       box1, box2, box3;
  logic       en1, en2, en3;
  logic [2:0] bit1, bit2, bit3;
  logic [3:0] line1, line2;
  vga_t       tim1, tim2, tim3, out_q;
  logic [7:0] font_data;
  logic       visible;

  font_rom u_font (
    .clk  (clk),
    .addr ({char_code, line2}),
    .data (font_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      char_xy <= '0;
      box1  <= 1'b0; box2  <= 1'b0; box3 <= 1'b0;
      en1   <= 1'b0; en2   <= 1'b0; en3  <= 1'b0;
      bit1  <= '0;   bit2  <= '0;   bit3 <= '0;
      line1 <= '0;   line2 <= '0;
      tim1  <= '0;   tim2  <= '0;   tim3 <= '0;
      out_q <= '0;
    end else begin
      // Stage 1: address the text ROM and capture the pixel's context
      char_xy <= in_box ? {dy[7:4], dx[6:3]} : '0;
      box1    <= in_box;
      en1     <= enable;
      bit1    <= dx[2:0];
      line1   <= dy[3:0];
      tim1    <= tim_in;
      // Stage 2: text ROM returns char_code
      box2  <= box1;  en2 <= en1;  bit2 <= bit1;  line2 <= line1;  tim2 <= tim1;
      // Stage 3: font ROM returns the glyph row
      box3  <= box2;  en3 <= en2;  bit3 <= bit2;  tim3 <= tim2;
      // Stage 4: ~bit3 == 7 - bit3, picking the MSB for the leftmost pixel
      out_q <= tim3;
      if (box3 && en3 && visible && font_data[~bit3])
        out_q.rgb <= FG_COLOR;
    end
  end

  // Blink: count vblnk rising edges, flip visibility every BLINK_FRAMES
  logic [15:0] frame_cnt;
  logic        vblnk_prev;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_cnt  <= '0;
      visible    <= 1'b1;
      vblnk_prev <= 1'b0;
    end else begin
      vblnk_prev <= vblnk_in;
      if (!enable || BLINK_FRAMES == 0) begin
        frame_cnt <= '0;
        visible   <= 1'b1;
      end else if (vblnk_in && !vblnk_prev) begin
        if (frame_cnt == 16'(BLINK_FRAMES - 1)) begin
          frame_cnt <= '0;
          visible   <= ~visible;
        end else begin
          frame_cnt <= frame_cnt + 16'd1;
        end
      end
    end
  end

  assign vcount_out = out_q.vcount;
  assign hcount_out = out_q.hcount;
  assign vsync_out  = out_q.vsync;
  assign vblnk_out  = out_q.vblnk;
  assign hsync_out  = out_q.hsync;
  assign hblnk_out  = out_q.hblnk;
  assign rgb_out    = out_q.rgb;

endmodule

// File: tb/tb_draw_text.sv
// tb/tb_draw_text.sv - directed bench for draw_text
module tb_draw_text;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b1;
  logic [10:0] vcount_in = '0, hcount_in = '0;
  logic        vsync_in = 1'b0, vblnk_in = 1'b0, hsync_in = 1'b0, hblnk_in = 1'b0;
  logic [11:0] rgb_in = '0;

  logic [7:0]  a_xy, e_xy;
  logic [6:0]  a_code, e_code;
  logic [10:0] a_vc, a_hc, e_vc, e_hc;
  logic        a_vs, a_vb, a_hs, a_hb, e_vs, e_vb, e_hs, e_hb;
  logic [11:0] a_rgb, e_rgb;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Text ROM models: every address holds "P"
  always @(posedge clk) begin
    a_code <= 7'h50;
    e_code <= 7'h50;
  end

  draw_text #(.XPOS(448), .YPOS(368), .COLS(16), .ROWS(1),
              .FG_COLOR(12'hfff), .BLINK_FRAMES(2)) u_a (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .vcount_in(vcount_in), .hcount_in(hcount_in),
    .vsync_in(vsync_in), .vblnk_in(vblnk_in), .hsync_in(hsync_in), .hblnk_in(hblnk_in),
    .rgb_in(rgb_in), .char_xy(a_xy), .char_code(a_code),
    .vcount_out(a_vc), .hcount_out(a_hc), .vsync_out(a_vs), .vblnk_out(a_vb),
    .hsync_out(a_hs), .hblnk_out(a_hb), .rgb_out(a_rgb)
  );

  draw_text #(.XPOS(0), .YPOS(0), .COLS(16), .ROWS(1),
              .FG_COLOR(12'hfff), .BLINK_FRAMES(0)) u_e (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .vcount_in(vcount_in), .hcount_in(hcount_in),
    .vsync_in(vsync_in), .vblnk_in(vblnk_in), .hsync_in(hsync_in), .hblnk_in(hblnk_in),
    .rgb_in(rgb_in), .char_xy(e_xy), .char_code(e_code),
    .vcount_out(e_vc), .hcount_out(e_hc), .vsync_out(e_vs), .vblnk_out(e_vb),
    .hsync_out(e_hs), .hblnk_out(e_hb), .rgb_out(e_rgb)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one pixel and let stage 1 capture it
  task automatic pix(input logic [10:0] h, input logic [10:0] v,
                     input logic [11:0] c, input logic en);
    hcount_in = h;
    vcount_in = v;
    rgb_in    = c;
    enable    = en;
    steps(1);
  endtask

  task automatic vrise();
    vblnk_in = 1'b1;
    steps(1);
    vblnk_in = 1'b0;
    steps(1);
  endtask

  logic [11:0] exp_rgb;
  logic [10:0] exp_hc;

  initial begin
    // Reset with random inputs
    for (int i = 0; i < 3; i++) begin
      hcount_in = 11'($urandom_range(0, 2047));
      vcount_in = 11'($urandom_range(0, 2047));
      rgb_in    = 12'($urandom);
      enable    = 1'($urandom);
      vsync_in  = 1'($urandom);
      hsync_in  = 1'($urandom);
      hblnk_in  = 1'($urandom);
      vblnk_in  = 1'($urandom);
      steps(1);
      check("rst_outputs", {a_vc, a_hc, a_vs, a_vb, a_hs, a_hb, a_rgb}, 64'd0);
      check("rst_char_xy", a_xy, 8'h00);
    end
    vsync_in = 1'b0; hsync_in = 1'b0; hblnk_in = 1'b0; vblnk_in = 1'b0;

    // Release: outside-box stream comes out 4 cycles late, zeros before that
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      pix(11'(100 + i), 11'd0, 12'(12'h100 + i), 1'b1);
      exp_hc  = (i >= 3) ? 11'(100 + i - 3) : 11'd0;
      exp_rgb = (i >= 3) ? 12'(12'h100 + i - 3) : 12'h000;
      check("lat_hcount", a_hc, exp_hc);
      check("lat_rgb", a_rgb, exp_rgb);
    end

    // Addressing
    pix(11'd456, 11'd368, 12'h0a0, 1'b1);
    check("addr_456", a_xy, 8'h01);
    pix(11'd575, 11'd368, 12'h0a0, 1'b1);
    check("addr_575", a_xy, 8'h0f);
    pix(11'd576, 11'd368, 12'h0a0, 1'b1);
    check("addr_576", a_xy, 8'h00);
    steps(3);
    check("rgb_576_outside", a_rgb, 12'h0a0);

    // Glyph "P" row 0 = fc: six lit pixels, two passthrough
    for (int i = 0; i < 8; i++) begin
      pix(11'(448 + i), 11'd368, 12'h0a0, 1'b1);
      steps(3);
      exp_rgb = (i < 6) ? 12'hfff : 12'h0a0;
      check("glyph_p_row0", a_rgb, exp_rgb);
    end

    // Disabled over the box: pure 4-cycle delay
    for (int i = 0; i < 16; i++) begin
      pix(11'(448 + i), 11'd368, 12'(12'h0a0 + i), 1'b0);
      if (i >= 3) begin
        exp_rgb = 12'(12'h0a0 + i - 3);
        check("disable_pass", a_rgb, exp_rgb);
      end
    end

    // Blink with BLINK_FRAMES = 2
    for (int f = 0; f < 6; f++) begin
      pix(11'd448, 11'd368, 12'h0a0, 1'b1);
      steps(3);
      exp_rgb = ((f / 2) % 2 == 1) ? 12'h0a0 : 12'hfff;
      check("blink_frame", a_rgb, exp_rgb);
      vrise();
    end

    // vblnk rise coinciding with enable fall: hold wins, restart visible at 0
    enable   = 1'b0;
    vblnk_in = 1'b1;
    steps(1);
    vblnk_in = 1'b0;
    steps(1);
    pix(11'd448, 11'd368, 12'h0a0, 1'b1);
    steps(3);
    check("reenable_visible", a_rgb, 12'hfff);
    vrise();
    pix(11'd448, 11'd368, 12'h0a0, 1'b1);
    steps(3);
    check("cnt_held_zero", a_rgb, 12'hfff);
    vrise();
    pix(11'd448, 11'd368, 12'h0a0, 1'b1);
    steps(3);
    check("blink_after_hold", a_rgb, 12'h0a0);

    // Box at the origin
    pix(11'd0, 11'd0, 12'h0a0, 1'b1);
    check("edge_xy_00", e_xy, 8'h00);
    steps(3);
    check("edge_rgb_00", e_rgb, 12'hfff);
    pix(11'd8, 11'd0, 12'h0a0, 1'b1);
    check("edge_xy_8", e_xy, 8'h01);
    pix(11'd2047, 11'd0, 12'h0a0, 1'b1);
    check("edge_xy_2047", e_xy, 8'h00);
    steps(3);
    check("edge_rgb_2047", e_rgb, 12'h0a0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
